// File: rtl/data_matrix_psr_unit_pkg.sv
// Shared PSR definitions for the data matrix: image bit positions, the packed
// PSR record held on the save stack, command encoding and image helpers.
package data_matrix_psr_unit_pkg;

  localparam int PSR_PRIV_BIT = 15;
  localparam int PSR_PRI_HI   = 10;
  localparam int PSR_PRI_LO   = 8;
  localparam int PSR_N_BIT    = 2;
  localparam int PSR_Z_BIT    = 1;
  localparam int PSR_P_BIT    = 0;
  localparam int PSR_IMG_W    = 16;

  typedef struct packed {
    logic       priv;
    logic [2:0] pri;
    logic       n;
    logic       z;
    logic       p;
  } psr_t;

  localparam int PSR_W = $bits(psr_t);

  // One command per cycle; the decode order below is the arbitration order.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INT_ENTRY,
    CMD_RTI,
    CMD_LD_PSR,
    CMD_LD_CC
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic int_entry, input logic rti,
                                      input logic ld_psr, input logic ld_cc);
    if (int_entry)   return CMD_INT_ENTRY;
    else if (rti)    return CMD_RTI;
    else if (ld_psr) return CMD_LD_PSR;
    else if (ld_cc)  return CMD_LD_CC;
    else             return CMD_NONE;
  endfunction

  function automatic logic [PSR_IMG_W-1:0] psr_to_image(input psr_t s);
    logic [PSR_IMG_W-1:0] img;
    img                         = '0;
    img[PSR_PRIV_BIT]           = s.priv;
    img[PSR_PRI_HI:PSR_PRI_LO]  = s.pri;
    img[PSR_N_BIT]              = s.n;
    img[PSR_Z_BIT]              = s.z;
    img[PSR_P_BIT]              = s.p;
    return img;
  endfunction

endpackage

// File: rtl/data_matrix_psr_stack.sv
// DEPTH-entry LIFO of PSR records used across nested interrupt entry / RTI,
// with occupancy count and sticky overflow/underflow detection.
module data_matrix_psr_stack
  import data_matrix_psr_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             err_clr_i,
  input  psr_t             wdata_i,
  output psr_t             rdata_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  psr_t             mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // The slot above the top is where the next push lands; the top itself is one below.
  assign wr_idx  = cnt_q[IDX_W-1:0];
  assign rd_idx  = empty_o ? '0 : wr_idx - IDX_W'(1);
  assign rdata_o = mem_q[rd_idx];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop) cnt_d = cnt_q - CNT_W'(1);

    // A fresh fault in the same cycle beats the clear, so it is never lost.
    ovf_d = ovf_q & ~err_clr_i;
    unf_d = unf_q & ~err_clr_i;
    if (push_i && full_o)  ovf_d = 1'b1;
    if (pop_i  && empty_o) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; cnt_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
  assign unf_o = unf_q;

endmodule

// File: rtl/data_matrix_psr_unit.sv
// Processor-status unit: NZP, privilege and priority registers, nested PSR save
// stack and bus image driver. Define DATA_MATRIX_PSR_TRISTATE_EN to float psr_out when ungated.
module data_matrix_psr_unit
  import data_matrix_psr_unit_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_cc,
  input  logic              cc_src_sel,
  input  logic              ld_psr,
  input  logic              int_entry,
  input  logic [2:0]        int_pri,
  input  logic              rti,
  input  logic              err_clr,
  input  logic              gate_psr_en,
  output logic [DATA_W-1:0] psr_out,
  output logic              reg_n,
  output logic              reg_z,
  output logic              reg_p,
  output logic              priv,
  output logic [2:0]        pri,
  output logic [CNT_W-1:0]  stk_cnt,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_unf
);

  psr_t              psr_q, psr_d;
  psr_t              stk_rdata;
  cmd_e              cmd;
  logic              push, pop;
  logic              cc_n, cc_z, cc_p;
  logic [DATA_W-1:0] img;

  assign cmd = decode_cmd(int_entry, rti, ld_psr, ld_cc);

  // Derived codes treat the bus as a signed DATA_W-bit value; exactly one is set.
  assign cc_z = ~|bus;
  assign cc_n = bus[DATA_W-1];
  assign cc_p = ~cc_n & ~cc_z;

  always_comb begin
    psr_d = psr_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (cmd)
      CMD_INT_ENTRY: begin
        // Privilege and priority change even when the push overflows.
        push       = 1'b1;
        psr_d.priv = 1'b0;
        psr_d.pri  = int_pri;
      end
      CMD_RTI: begin
        pop = 1'b1;
        if (!stk_empty) psr_d = stk_rdata;
      end
      CMD_LD_PSR: begin
        psr_d.priv = bus[PSR_PRIV_BIT];
        psr_d.pri  = bus[PSR_PRI_HI:PSR_PRI_LO];
        psr_d.n    = bus[PSR_N_BIT];
        psr_d.z    = bus[PSR_Z_BIT];
        psr_d.p    = bus[PSR_P_BIT];
      end
      CMD_LD_CC: begin
        if (cc_src_sel) {psr_d.n, psr_d.z, psr_d.p} = bus[2:0];
        else            {psr_d.n, psr_d.z, psr_d.p} = {cc_n, cc_z, cc_p};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psr_q <= '0;
    else        psr_q <= psr_d;
  end

  data_matrix_psr_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .err_clr_i (err_clr),
    .wdata_i   (psr_q),
    .rdata_o   (stk_rdata),
    .cnt_o     (stk_cnt),
    .full_o    (stk_full),
    .empty_o   (stk_empty),
    .ovf_o     (stk_ovf),
    .unf_o     (stk_unf)
  );

  always_comb begin
    img                  = '0;
    img[PSR_IMG_W-1:0]   = psr_to_image(psr_q);
  end

`ifdef DATA_MATRIX_PSR_TRISTATE_EN
  assign psr_out = gate_psr_en ? img : {DATA_W{1'bz}};
`else
  assign psr_out = gate_psr_en ? img : {DATA_W{1'b0}};
`endif

  assign reg_n = psr_q.n;
  assign reg_z = psr_q.z;
  assign reg_p = psr_q.p;
  assign priv  = psr_q.priv;
  assign pri   = psr_q.pri;

endmodule

// File: tb/tb_data_matrix_psr_unit.sv
// Self-checking bench for data_matrix_psr_unit: vector table plus a small stack
// model for nested interrupt, overflow/underflow, gating and mid-cycle reset cases.
module tb_data_matrix_psr_unit;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] bus;
  logic              ld_cc, cc_src_sel, ld_psr, int_entry, rti, err_clr, gate_psr_en;
  logic [2:0]        int_pri;
  logic [DATA_W-1:0] psr_out;
  logic              reg_n, reg_z, reg_p, priv;
  logic [2:0]        pri;
  logic [CNT_W-1:0]  stk_cnt;
  logic              stk_full, stk_empty, stk_ovf, stk_unf;

  always #5 clk = ~clk;

  data_matrix_psr_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ld_cc(ld_cc), .cc_src_sel(cc_src_sel),
    .ld_psr(ld_psr), .int_entry(int_entry), .int_pri(int_pri), .rti(rti),
    .err_clr(err_clr), .gate_psr_en(gate_psr_en), .psr_out(psr_out),
    .reg_n(reg_n), .reg_z(reg_z), .reg_p(reg_p), .priv(priv), .pri(pri),
    .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  typedef struct {
    logic [2:0]       nzp;
    logic             priv;
    logic [2:0]       pri;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             unf;
    logic [15:0]      img;
  } exp_t;

  typedef struct {
    string       name;
    logic        ld_cc, sel, ld_psr, ie;
    logic [2:0]  ipri;
    logic        rti, clr;
    logic [15:0] bus;
    exp_t        e;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  // Reference model for the sequence tests.
  logic [15:0] m_img;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [2:0] nzp, input logic pv, input logic [2:0] pr,
                                  input int cnt, input logic ovf, input logic unf,
                                  input logic [15:0] img);
    exp_t e;
    e.nzp = nzp; e.priv = pv; e.pri = pr; e.cnt = CNT_W'(cnt);
    e.ovf = ovf; e.unf = unf; e.img = img;
    return e;
  endfunction

  task automatic compare_state(input string name, input exp_t e);
    check({name, ".nzp"},   {29'd0, reg_n, reg_z, reg_p}, {29'd0, e.nzp});
    check({name, ".priv"},  {31'd0, priv}, {31'd0, e.priv});
    check({name, ".pri"},   {29'd0, pri}, {29'd0, e.pri});
    check({name, ".cnt"},   32'(stk_cnt), 32'(e.cnt));
    check({name, ".full"},  {31'd0, stk_full}, {31'd0, (e.cnt == CNT_W'(DEPTH))});
    check({name, ".empty"}, {31'd0, stk_empty}, {31'd0, (e.cnt == '0)});
    check({name, ".ovf"},   {31'd0, stk_ovf}, {31'd0, e.ovf});
    check({name, ".unf"},   {31'd0, stk_unf}, {31'd0, e.unf});
    check({name, ".psr_out"}, {16'd0, psr_out}, {16'd0, e.img});
  endtask

  task automatic drive(input logic l_cc, input logic sel, input logic l_psr, input logic ie,
                       input logic [2:0] ipri, input logic r, input logic clr,
                       input logic [15:0] b);
    ld_cc = l_cc; cc_src_sel = sel; ld_psr = l_psr; int_entry = ie;
    int_pri = ipri; rti = r; err_clr = clr; bus = b;
  endtask

  task automatic clear_cmds();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Expected result is queued when the command is driven and retired after the edge.
  task automatic step(input string name, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clear_cmds();
    if (sb.size() == 0) begin
      check({name, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      compare_state(name, got);
    end
  endtask

  function automatic exp_t model_exp();
    return mk_exp(m_img[2:0], m_img[15], m_img[10:8], m_stk.size(), m_ovf, m_unf, m_img);
  endfunction

  task automatic model_cmd(input logic ie, input logic [2:0] ipri, input logic r,
                           input logic clr);
    logic ovf_evt, unf_evt;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (ie) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_img);
      else                      ovf_evt = 1'b1;
      m_img = {1'b0, 4'b0000, ipri, 5'b00000, m_img[2:0]};
    end else if (r) begin
      if (m_stk.size() > 0) m_img = m_stk.pop_back();
      else                  unf_evt = 1'b1;
    end
    m_ovf = ovf_evt | (m_ovf & ~clr);
    m_unf = unf_evt | (m_unf & ~clr);
  endtask

  task automatic seq_cmd(input string name, input logic ie, input logic [2:0] ipri,
                         input logic r, input logic clr);
    drive(1'b0, 1'b0, 1'b0, ie, ipri, r, clr, 16'h0000);
    model_cmd(ie, ipri, r, clr);
    step(name, model_exp());
  endtask

  task automatic add_vec(input string name, input logic l_cc, input logic sel,
                         input logic l_psr, input logic ie, input logic [2:0] ipri,
                         input logic r, input logic clr, input logic [15:0] b,
                         input exp_t e);
    vec_t v;
    v.name = name; v.ld_cc = l_cc; v.sel = sel; v.ld_psr = l_psr; v.ie = ie;
    v.ipri = ipri; v.rti = r; v.clr = clr; v.bus = b; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] gate_exp;

    //        name            cc sel psr ie pri rti clr bus         nzp  pv pri cnt ovf unf image
    add_vec("cc_neg",        1, 0, 0, 0, 3'd0, 0, 0, 16'h8001, mk_exp(3'b100, 0, 3'd0, 0, 0, 0, 16'h0004));
    add_vec("cc_zero",       1, 0, 0, 0, 3'd0, 0, 0, 16'h0000, mk_exp(3'b010, 0, 3'd0, 0, 0, 0, 16'h0002));
    add_vec("cc_pos",        1, 0, 0, 0, 3'd0, 0, 0, 16'h7FFF, mk_exp(3'b001, 0, 3'd0, 0, 0, 0, 16'h0001));
    add_vec("cc_verbatim",   1, 1, 0, 0, 3'd0, 0, 0, 16'h0005, mk_exp(3'b101, 0, 3'd0, 0, 0, 0, 16'h0005));
    add_vec("ld_psr",        0, 0, 1, 0, 3'd0, 0, 0, 16'h8602, mk_exp(3'b010, 1, 3'd6, 0, 0, 0, 16'h8602));
    add_vec("int_entry",     0, 0, 0, 1, 3'd3, 0, 0, 16'h0000, mk_exp(3'b010, 0, 3'd3, 1, 0, 0, 16'h0302));
    add_vec("rti_restore",   0, 0, 0, 0, 3'd0, 1, 0, 16'h0000, mk_exp(3'b010, 1, 3'd6, 0, 0, 0, 16'h8602));
    add_vec("rti_empty",     0, 0, 0, 0, 3'd0, 1, 0, 16'h0000, mk_exp(3'b010, 1, 3'd6, 0, 0, 1, 16'h8602));
    add_vec("err_clr",       0, 0, 0, 0, 3'd0, 0, 1, 16'h0000, mk_exp(3'b010, 1, 3'd6, 0, 0, 0, 16'h8602));
    add_vec("prio_int_wins", 1, 0, 0, 1, 3'd5, 1, 0, 16'h8001, mk_exp(3'b010, 0, 3'd5, 1, 0, 0, 16'h0502));
    add_vec("prio_psr_wins", 1, 0, 1, 0, 3'd0, 0, 0, 16'h0107, mk_exp(3'b111, 0, 3'd1, 1, 0, 0, 16'h0107));
    add_vec("prio_rti_wins", 0, 0, 1, 0, 3'd0, 1, 0, 16'hFFFF, mk_exp(3'b010, 1, 3'd6, 0, 0, 0, 16'h8602));
    add_vec("cc_all_ones",   1, 0, 0, 0, 3'd0, 0, 0, 16'hFFFF, mk_exp(3'b100, 1, 3'd6, 0, 0, 0, 16'h8604));

    rst_n       = 1'b0;
    gate_psr_en = 1'b1;
    clear_cmds();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_state("reset", mk_exp(3'b000, 0, 3'd0, 0, 0, 0, 16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i].ld_cc, vecs[i].sel, vecs[i].ld_psr, vecs[i].ie, vecs[i].ipri,
            vecs[i].rti, vecs[i].clr, vecs[i].bus);
      step(vecs[i].name, vecs[i].e);
    end

    // Nested entry past DEPTH, LIFO unwind, then one pop too many.
    m_img = 16'h8604;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) seq_cmd($sformatf("nest_push%0d", i), 1'b1, 3'(i), 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++)     seq_cmd($sformatf("nest_pop%0d", i), 1'b0, 3'd0, 1'b1, 1'b0);
    seq_cmd("pop_underflow", 1'b0, 3'd0, 1'b1, 1'b0);
    seq_cmd("flags_clear", 1'b0, 3'd0, 1'b0, 1'b1);

    // Refill, then overflow in the same cycle as err_clr: the flag must survive.
    for (int i = 0; i < DEPTH; i++) seq_cmd($sformatf("refill%0d", i), 1'b1, 3'(7 - i), 1'b0, 1'b0);
    seq_cmd("ovf_beats_clr", 1'b1, 3'd3, 1'b0, 1'b1);

    gate_psr_en = 1'b0;
    #1;
`ifdef DATA_MATRIX_PSR_TRISTATE_EN
    gate_exp = 16'hzzzz;
`else
    gate_exp = 16'h0000;
`endif
    check("gate_off.psr_out", {16'd0, psr_out}, {16'd0, gate_exp});
    gate_psr_en = 1'b1;

    // Reset asserted between edges while a push is pending.
    seq_cmd("pre_rst_pop", 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    compare_state("async_rst", mk_exp(3'b000, 0, 3'd0, 0, 0, 0, 16'h0000));
    clear_cmds();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_img = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    seq_cmd("post_rst_rti", 1'b0, 3'd0, 1'b1, 1'b0);
    seq_cmd("post_rst_push", 1'b1, 3'd4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
